// File: rtl/gpt_pkg.sv
// Shared types and defaults for the general-purpose timer input front ends.
package gpt_pkg;

   localparam int ETR_SYNC_STAGES_DEF = 2;
   localparam int GPT_PSC_W           = 2;
   localparam int GPT_FLT_W           = 4;

   typedef logic [GPT_PSC_W-1:0] etps_t;
   typedef logic [GPT_FLT_W-1:0] etf_t;

endpackage

// File: rtl/gpt_sync.sv
// Multi-flop async-reset bit synchroniser for timer input pins.
module gpt_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic aresetn,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/etr_conditioner.sv
// External trigger front end: synchronise, polarity, glitch filter, edge detect,
// then divide qualified edges by 2^etps_i into one-clock trigger pulses.
module etr_conditioner
   import gpt_pkg::*;
#(
   parameter int SYNC_STAGES = ETR_SYNC_STAGES_DEF,
   parameter int PSC_W       = GPT_PSC_W,
   parameter int FLT_W       = GPT_FLT_W
) (
   input  logic             clk_i,
   input  logic             aresetn_i,
   input  logic             en_i,
   input  logic             etr_i,
   input  logic             etp_i,
   input  logic             bedge_i,
   input  logic [FLT_W-1:0] etf_i,
   input  logic [PSC_W-1:0] etps_i,
   output logic             etrf_o,
   output logic             trig_o
);

   localparam int CNT_W = (1 << PSC_W) - 1;

   logic             sync_q;
   logic             pol;
   logic [FLT_W-1:0] flt_cnt;
   logic             etrf_d;
   logic             rise;
   logic             fall;
   logic             qual_edge;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div_max;
   logic [PSC_W-1:0] etps_q;

   gpt_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk_i),
      .aresetn (aresetn_i),
      .d       (etr_i),
      .q       (sync_q)
   );

   assign pol = sync_q ^ etp_i;

   // >= rather than == so a run already past a freshly lowered etf_i still toggles.
   always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         flt_cnt <= '0;
         etrf_o  <= 1'b0;
      end else if (pol == etrf_o) begin
         flt_cnt <= '0;
      end else if (flt_cnt >= etf_i) begin
         flt_cnt <= '0;
         etrf_o  <= ~etrf_o;
      end else begin
         flt_cnt <= flt_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i) etrf_d <= 1'b0;
      else            etrf_d <= etrf_o;
   end

   assign rise      = etrf_o & ~etrf_d;
   assign fall      = ~etrf_o & etrf_d;
   assign qual_edge = rise | (bedge_i & fall);

   // Wraps to all-ones for the largest ratio, which is exactly the terminal count.
   assign div_max = (CNT_W'(1) << etps_i) - CNT_W'(1);

   always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         cnt    <= '0;
         trig_o <= 1'b0;
         etps_q <= '0;
      end else begin
         etps_q <= etps_i;
         if (!en_i || (etps_i != etps_q)) begin
            cnt    <= '0;
            trig_o <= 1'b0;
         end else if (qual_edge) begin
            if (cnt == div_max) begin
               cnt    <= '0;
               trig_o <= 1'b1;
            end else begin
               cnt    <= cnt + 1'b1;
               trig_o <= 1'b0;
            end
         end else begin
            trig_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_etr_conditioner.sv
// Bench for etr_conditioner: directed scenarios plus random pulses against a
// sample-history reference model; trigger cycles go through a scoreboard queue.
module tb_etr_conditioner;

   localparam int SYNC  = 2;
   localparam int PSC_W = 2;
   localparam int FLT_W = 4;
   localparam int WIN   = 1 << FLT_W;

   logic             clk_i = 1'b0;
   logic             aresetn_i;
   logic             en_i;
   logic             etr_i;
   logic             etp_i;
   logic             bedge_i;
   logic [FLT_W-1:0] etf_i;
   logic [PSC_W-1:0] etps_i;
   logic             etrf_o;
   logic             trig_o;

   always #5 clk_i = ~clk_i;

   etr_conditioner #(.SYNC_STAGES(SYNC), .PSC_W(PSC_W), .FLT_W(FLT_W)) dut (
      .clk_i     (clk_i),
      .aresetn_i (aresetn_i),
      .en_i      (en_i),
      .etr_i     (etr_i),
      .etp_i     (etp_i),
      .bedge_i   (bedge_i),
      .etf_i     (etf_i),
      .etps_i    (etps_i),
      .etrf_o    (etrf_o),
      .trig_o    (trig_o)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic [31:0] exp_q[$];

   // Reference model state: raw pin samples, filter-input history, filtered level,
   // and the number of qualified edges seen since the divider last restarted.
   bit samp[$];
   bit pol_win[$];
   bit lvl;
   bit tog_prev;
   int edges_seen;
   int etps_prev;

   function automatic void model_reset();
      samp = {};
      pol_win = {};
      for (int i = 0; i < SYNC; i++) samp.push_back(1'b0);
      for (int i = 0; i < WIN; i++) pol_win.push_back(1'b0);
      lvl        = 1'b0;
      tog_prev   = 1'b0;
      edges_seen = 0;
      etps_prev  = 0;
   endfunction

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endfunction

   // One clock: predict what the coming edge does, then advance and check etrf_o.
   task automatic step();
      bit p;
      bit tog;
      bit ed;
      bit trig;
      p = samp.pop_front();
      samp.push_back(etr_i);
      p = p ^ etp_i;
      void'(pol_win.pop_front());
      pol_win.push_back(p);
      tog = 1'b1;
      for (int k = 0; k <= int'(etf_i); k++)
         if (pol_win[pol_win.size() - 1 - k] == lvl) tog = 1'b0;
      ed   = tog_prev && (lvl || bedge_i);
      trig = 1'b0;
      if (!en_i || int'(etps_i) != etps_prev) begin
         edges_seen = 0;
      end else if (ed) begin
         edges_seen++;
         if (edges_seen == (1 << etps_i)) begin
            trig       = 1'b1;
            edges_seen = 0;
         end
      end
      etps_prev = int'(etps_i);
      lvl       = lvl ^ tog;
      tog_prev  = tog;
      if (trig) exp_q.push_back(32'(cyc + 1));
      @(posedge clk_i);
      cyc++;
      #1;
      check("etrf_o", 32'(etrf_o), 32'(lvl));
   endtask

   task automatic pulse(input int hi, input int lo);
      etr_i = 1'b1;
      repeat (hi) step();
      etr_i = 1'b0;
      repeat (lo) step();
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      #1 aresetn_i = 1'b0;
      #1;
      check("rst_trig_o", 32'(trig_o), 32'd0);
      check("rst_etrf_o", 32'(etrf_o), 32'd0);
      #1 aresetn_i = 1'b1;
      model_reset();
   endtask

   // Scoreboard monitor: an expected trigger is due exactly at its cycle stamp.
   always @(negedge clk_i) begin
      if (aresetn_i) begin
         if (exp_q.size() > 0 && exp_q[0] == 32'(cyc)) begin
            void'(exp_q.pop_front());
            check("trig_o_expected", 32'(trig_o), 32'd1);
         end else if (trig_o !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL trig_o_spurious: got %b expected 0 at cycle %0d", trig_o, cyc);
         end
      end
   end

   initial begin
      aresetn_i = 1'b0;
      en_i      = 1'b1;
      etr_i     = 1'b0;
      etp_i     = 1'b0;
      bedge_i   = 1'b0;
      etf_i     = '0;
      etps_i    = '0;
      model_reset();
      #2;
      check("reset_trig_o", 32'(trig_o), 32'd0);
      check("reset_etrf_o", 32'(etrf_o), 32'd0);
      #7 aresetn_i = 1'b1;

      // Bypass filter, divide by 1: three clean pulses.
      repeat (4) step();
      repeat (3) pulse(4, 4);

      // Filter length 4: short glitch rejected, longer pulse passes.
      etf_i = 4'd3;
      pulse(2, 8);
      pulse(5, 8);

      // Divide by 4, then by 8.
      etf_i  = 4'd0;
      etps_i = 2'd2;
      repeat (8) pulse(2, 2);
      etps_i = 2'd3;
      repeat (16) pulse(2, 2);

      // Both edges, inverted polarity, divide by 2.
      bedge_i = 1'b1;
      etp_i   = 1'b1;
      etps_i  = 2'd1;
      repeat (6) step();
      repeat (3) pulse(3, 3);
      bedge_i = 1'b0;
      etp_i   = 1'b0;
      repeat (6) step();

      // Ratio change mid-count.
      etps_i = 2'd2;
      repeat (3) pulse(2, 2);
      etps_i = 2'd1;
      repeat (4) pulse(2, 2);

      // Enable drop mid-count, then reset while the filtered level is high.
      etps_i = 2'd2;
      repeat (2) pulse(2, 2);
      en_i = 1'b0;
      repeat (4) step();
      en_i = 1'b1;
      repeat (4) pulse(2, 2);
      etr_i = 1'b1;
      repeat (6) step();
      do_reset();
      repeat (10) step();
      etr_i = 1'b0;
      repeat (4) step();

      // Random configuration and pulse widths.
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            etf_i   = 4'($urandom_range(0, 3));
            etps_i  = 2'($urandom_range(0, 3));
            bedge_i = 1'($urandom_range(0, 1));
            etp_i   = 1'($urandom_range(0, 1));
            en_i    = ($urandom_range(0, 7) != 0);
         end
         pulse($urandom_range(1, 7), $urandom_range(1, 7));
      end
      repeat (10) step();

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
